// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, default widths and redirect target arithmetic for the fetch unit
package fetch_pkg;
   localparam int ADDR_W_DEF  = 8;
   localparam int INSTR_W_DEF = 8;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_e;
   // callers truncate the result to their PC width, which yields the modulo sum
   function automatic logic [31:0] next_target(input logic [31:0] base, input logic [31:0] off, input logic rel);
      return rel ? base + 32'd1 + off : base;
   endfunction
endpackage

// File: rtl/fetch_unit_param_fifo.sv
// fetch_fifo: show-ahead synchronous FIFO with clear and occupancy count
module fetch_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           clear_i,
   input  logic                           push_i,
   input  logic                           pop_i,
   input  logic [WIDTH-1:0]               data_i,
   output logic [WIDTH-1:0]               data_o,
   output logic                           valid_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= DEPTH == 1 ? '0 : wr_ptr_q + PW'(1);
         if (pop_i) rd_ptr_q <= DEPTH == 1 ? '0 : rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   always_ff @(posedge Clk)
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
   assign data_o  = mem_q[rd_ptr_q];
   assign valid_o = count_q != '0;
   assign count_o = count_q;
endmodule

// File: rtl/fetch_unit_param.sv
// fetch_unit_param: PC-driven instruction fetch over req/ack memory with prefetch FIFO and redirect flush
module fetch_unit_param import fetch_pkg::*; #(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int INSTR_W   = INSTR_W_DEF,
   parameter int BUF_DEPTH = 2,
   parameter int RESET_PC  = 0
) (
   input  logic               Clk,
   input  logic               Reset,
   output logic               Mem_Req,
   output logic [ADDR_W-1:0]  Mem_Addr,
   input  logic               Mem_Ack,
   input  logic [INSTR_W-1:0] Mem_Data,
   output logic               Instr_Valid,
   input  logic               Instr_Ready,
   output logic [INSTR_W-1:0] Instr_Code,
   output logic [ADDR_W-1:0]  Instr_PC,
   input  logic               Redirect,
   input  logic               Redirect_Rel,
   input  logic [ADDR_W-1:0]  Redirect_Base,
   input  logic [ADDR_W-1:0]  Redirect_Off
);
   localparam int CW = $clog2(BUF_DEPTH+1);
   localparam int FW = INSTR_W + ADDR_W;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d, target;
   logic              req_q, req_d, push, pop, busy, issue, head_valid;
   logic [CW-1:0]     count;
   logic [CW:0]       occ;
   logic [FW-1:0]     head;
   assign target = ADDR_W'(next_target(32'(Redirect_Base), 32'(Redirect_Off), Redirect_Rel));
   assign pop    = head_valid && Instr_Ready;
   fetch_fifo #(.WIDTH(FW), .DEPTH(BUF_DEPTH)) u_fifo (
      .Clk     (Clk),
      .Reset   (Reset),
      .clear_i (Redirect),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  ({Mem_Data, addr_q}),
      .data_o  (head),
      .valid_o (head_valid),
      .count_o (count)
   );
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= ADDR_W'(RESET_PC);
         req_q      <= 1'b0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
      end
   // occ is next-cycle FIFO occupancy; a redirect empties the FIFO so space always exists
   always_comb begin
      busy    = state_q != S_IDLE && !Mem_Ack;
      push    = state_q == S_REQ && Mem_Ack && !Redirect;
      occ     = Redirect ? '0 : (CW+1)'(count) - (CW+1)'(pop) + (CW+1)'(push);
      issue   = !busy && occ < (CW+1)'(BUF_DEPTH);
      state_d = busy ? (Redirect ? S_DISCARD : state_q) : (issue ? S_REQ : S_IDLE);
   end
   always_comb begin
      fetch_pc_d = Redirect ? target : (push ? addr_q + ADDR_W'(1) : fetch_pc_q);
      req_d      = state_d != S_IDLE;
      addr_d     = issue ? fetch_pc_d : addr_q;
   end
   assign Mem_Req     = req_q;
   assign Mem_Addr    = addr_q;
   assign Instr_Valid = head_valid;
   assign Instr_Code  = head_valid ? head[FW-1:ADDR_W] : '0;
   assign Instr_PC    = head_valid ? head[ADDR_W-1:0] : '0;
endmodule

// File: tb/tb_fetch_unit_param.sv
// tb_fetch_unit_param: directed checks of fetch_unit_param against a latency-configurable memory model
module tb_fetch_unit_param;
   logic       Clk = 1'b0, Reset = 1'b1;
   logic       Mem_Req, Mem_Ack = 1'b0, Instr_Valid, Instr_Ready = 1'b1;
   logic       Redirect = 1'b0, Redirect_Rel = 1'b0;
   logic [7:0] Mem_Addr, Mem_Data = 8'h00, Instr_Code, Instr_PC;
   logic [7:0] Redirect_Base = 8'h00, Redirect_Off = 8'h00;
   int         n_chk = 0, n_pass = 0, lat = 1, wcnt = 0, bad_fifo = 0;
   fetch_unit_param #(.ADDR_W(8), .INSTR_W(8), .BUF_DEPTH(2), .RESET_PC(0)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Mem_Req       (Mem_Req),
      .Mem_Addr      (Mem_Addr),
      .Mem_Ack       (Mem_Ack),
      .Mem_Data      (Mem_Data),
      .Instr_Valid   (Instr_Valid),
      .Instr_Ready   (Instr_Ready),
      .Instr_Code    (Instr_Code),
      .Instr_PC      (Instr_PC),
      .Redirect      (Redirect),
      .Redirect_Rel  (Redirect_Rel),
      .Redirect_Base (Redirect_Base),
      .Redirect_Off  (Redirect_Off)
   );
   always #5 Clk = ~Clk;
   // memory answers Addr^0xA5 in the lat-th cycle of each request
   initial forever begin
      @(negedge Clk);
      if (Reset || !Mem_Req) begin
         Mem_Ack = 1'b0;
         wcnt = 0;
      end else if (wcnt >= lat - 1) begin
         Mem_Ack = 1'b1;
         Mem_Data = Mem_Addr ^ 8'hA5;
         wcnt = 0;
      end else begin
         Mem_Ack = 1'b0;
         wcnt++;
      end
   end
   always @(posedge Clk)
      if (!Reset && ((dut.u_fifo.push_i && !dut.u_fifo.pop_i && dut.u_fifo.count_o == 2'd2) ||
                     (dut.u_fifo.pop_i && dut.u_fifo.count_o == 2'd0)))
         bad_fifo++;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask
   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask
   task automatic redirect(input logic rel, input logic [7:0] base, input logic [7:0] off);
      Redirect = 1'b1;
      Redirect_Rel = rel;
      Redirect_Base = base;
      Redirect_Off = off;
      tick();
      Redirect = 1'b0;
   endtask
   initial begin
      #1;
      chk("rst_req", Mem_Req, 0);
      chk("rst_addr", Mem_Addr, 0);
      chk("rst_valid", Instr_Valid, 0);
      chk("rst_code", Instr_Code, 0);
      chk("rst_pc", Instr_PC, 0);
      // zero-wait streaming
      lat = 1;
      Instr_Ready = 1'b1;
      do_reset();
      tick();
      chk("t1_req", Mem_Req, 1);
      chk("t1_addr", Mem_Addr, 0);
      chk("t1_valid0", Instr_Valid, 0);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] pc;
         pc = 8'(i);
         tick();
         chk("t1_valid", Instr_Valid, 1);
         chk("t1_pc", Instr_PC, pc);
         chk("t1_code", Instr_Code, pc ^ 8'hA5);
      end
      // back-pressure fills the FIFO, one pop frees exactly one request
      Instr_Ready = 1'b0;
      do_reset();
      tick();
      tick();
      chk("t2_addr1", Mem_Addr, 1);
      tick();
      chk("t2_req_off", Mem_Req, 0);
      chk("t2_head", Instr_PC, 0);
      tick();
      chk("t2_req_off2", Mem_Req, 0);
      Instr_Ready = 1'b1;
      tick();
      Instr_Ready = 1'b0;
      chk("t2_req_on", Mem_Req, 1);
      chk("t2_addr2", Mem_Addr, 2);
      chk("t2_head1", Instr_PC, 1);
      tick();
      chk("t2_req_off3", Mem_Req, 0);
      // redirect during a slow request enters discard
      lat = 3;
      Instr_Ready = 1'b1;
      do_reset();
      for (int i = 0; i < 100 && !(Mem_Req && Mem_Addr == 8'h05); i++) tick();
      chk("t3_reach5", Mem_Addr, 8'h05);
      tick();
      redirect(1'b0, 8'h40, 8'h00);
      chk("t3_hold_req", Mem_Req, 1);
      chk("t3_hold_addr", Mem_Addr, 8'h05);
      tick();
      chk("t3_tgt_addr", Mem_Addr, 8'h40);
      chk("t3_no_push", Instr_Valid, 0);
      for (int i = 0; i < 20 && !Instr_Valid; i++) tick();
      chk("t3_first_pc", Instr_PC, 8'h40);
      chk("t3_first_code", Instr_Code, 8'hE5);
      // relative redirect and PC wrap
      lat = 1;
      tick();
      tick();
      redirect(1'b1, 8'hFE, 8'h05);
      chk("t4_rel_addr", Mem_Addr, 8'h04);
      chk("t4_rel_req", Mem_Req, 1);
      redirect(1'b0, 8'hFD, 8'h00);
      chk("t4_fd", Mem_Addr, 8'hFD);
      tick();
      chk("t4_fe", Mem_Addr, 8'hFE);
      tick();
      chk("t4_ff", Mem_Addr, 8'hFF);
      tick();
      chk("t4_wrap", Mem_Addr, 8'h00);
      tick();
      chk("t4_wrap_pc", Instr_PC, 8'h00);
      // redirect coincident with ack and decode handshake
      chk("t5_pre_valid", Instr_Valid, 1);
      chk("t5_pre_req", Mem_Req, 1);
      redirect(1'b0, 8'h80, 8'h00);
      chk("t5_valid", Instr_Valid, 0);
      chk("t5_req", Mem_Req, 1);
      chk("t5_addr", Mem_Addr, 8'h80);
      tick();
      chk("t5_pc", Instr_PC, 8'h80);
      chk("t5_code", Instr_Code, 8'h25);
      // asynchronous reset mid-request with one buffered entry
      lat = 3;
      Instr_Ready = 1'b0;
      do_reset();
      repeat (4) tick();
      chk("t6_valid", Instr_Valid, 1);
      chk("t6_req", Mem_Req, 1);
      chk("t6_addr", Mem_Addr, 1);
      #2 Reset = 1'b1;
      #1;
      chk("t6_req0", Mem_Req, 0);
      chk("t6_addr0", Mem_Addr, 0);
      chk("t6_valid0", Instr_Valid, 0);
      chk("t6_code0", Instr_Code, 0);
      chk("t6_pc0", Instr_PC, 0);
      tick();
      Reset = 1'b0;
      tick();
      chk("t6_restart_req", Mem_Req, 1);
      chk("t6_restart_addr", Mem_Addr, 0);
      chk("fifo_ovf_udf", bad_fifo, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
